// File: rtl/sign_narrow_pkg.sv
// Shared types and constants for the 32->16 signed narrowing block.
// SIGN_NARROW_SAT_EN selects saturation instead of truncation on overflow.
package sign_narrow_pkg;

    localparam int WORD_W = 32;
    localparam int HALF_W = 16;
    localparam logic [HALF_W-1:0] HALF_MAX = 16'h7FFF;
    localparam logic [HALF_W-1:0] HALF_MIN = 16'h8000;

    typedef struct packed {
        logic [HALF_W-1:0] data;
        logic              ovf;
    } entry_t;

    // Overflow when the top 17 bits are not a pure sign extension.
    function automatic entry_t narrow(input logic [WORD_W-1:0] w);
        entry_t e;
        e.ovf  = !((&w[WORD_W-1:HALF_W-1]) || !(|w[WORD_W-1:HALF_W-1]));
        e.data = w[HALF_W-1:0];
`ifdef SIGN_NARROW_SAT_EN
        if (e.ovf) begin
            e.data = w[WORD_W-1] ? HALF_MIN : HALF_MAX;
        end
`endif
        return e;
    endfunction

endpackage

// File: rtl/sign_narrow_if.sv
// Valid/ready stream bundle: 32-bit words in, narrowed halfwords out.
interface sign_narrow_if;
    import sign_narrow_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [HALF_W-1:0] out_data;
    logic              out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );

endinterface

// File: rtl/narrow_fifo2.sv
// Two-entry FIFO; slot 0 is always the head, in_ready is fully registered.
module narrow_fifo2 #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] s0_q, s0_d;
    logic [W-1:0] s1_q, s1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         ready_q, ready_d;
    logic         push, pop;

    assign in_ready  = ready_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = s0_q;
    assign push      = in_valid & ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        s0_d  = s0_q;
        s1_d  = s1_q;
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    s0_d = in_data;
                end else begin
                    s0_d = s1_q;
                    s1_d = in_data;
                end
            end
            2'b01: begin
                s0_d  = s1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    s0_d = in_data;
                end else begin
                    s1_d = in_data;
                end
                cnt_d = cnt_q + 2'd1;
            end
            default: ;
        endcase
        // Ready reflects next occupancy, so out_ready never reaches in_ready
        ready_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q    <= '0;
            s1_q    <= '0;
            cnt_q   <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: rtl/sign_narrow.sv
// Narrows signed 32-bit words to 16 bits through a 2-deep FIFO, counting
// overflows. Define SIGN_NARROW_SAT_EN to saturate instead of truncate.
module sign_narrow
    import sign_narrow_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    sign_narrow_if.slave     bus,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] ovf_cnt
);

    entry_t            in_ent;
    entry_t            out_ent;
    logic              fifo_ready;
    logic              push;
    logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        in_ent = narrow(bus.in_data);
    end

    narrow_fifo2 #(
        .W($bits(entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (fifo_ready),
        .in_data   (in_ent),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_ent)
    );

    assign bus.in_ready = fifo_ready;
    assign bus.out_data = out_ent.data;
    assign bus.out_ovf  = out_ent.ovf;
    assign push         = bus.in_valid & fifo_ready;
    assign ovf_cnt      = ovf_cnt_q;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (clr_cnt) begin
            ovf_cnt_d = '0;
        end else if (push && in_ent.ovf && !(&ovf_cnt_q)) begin
            ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

endmodule

// File: tb/tb_sign_narrow.sv
// Self-checking bench for sign_narrow: directed cases plus randomized
// traffic against a queue-based reference model.
module tb_sign_narrow;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SIGN_NARROW_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             clr_cnt;
    logic [CNT_W-1:0] ovf_cnt;

    sign_narrow_if bus ();

    sign_narrow #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .clr_cnt (clr_cnt),
        .ovf_cnt (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [16:0] mq[$];
    bit          m_rdy;
    int          m_cnt;

    function automatic logic [16:0] model(input logic [31:0] w);
        int          v;
        bit          o;
        logic [15:0] d;
        v = signed'(w);
        o = (v > 32767) || (v < -32768);
        d = w[15:0];
        if (o && SAT) d = (v < 0) ? 16'h8000 : 16'h7FFF;
        return {d, o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare();
        chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        chk("ovf_cnt", 32'(ovf_cnt), 32'(m_cnt));
        if (mq.size() != 0) begin
            chk("out_data", 32'(bus.out_data), 32'(mq[0][16:1]));
            chk("out_ovf", 32'(bus.out_ovf), 32'(mq[0][0]));
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rdy = 1'b0;
        m_cnt = 0;
    endtask

    task automatic step(input bit v, input logic [31:0] d,
                        input bit ordy, input bit clr);
        logic [16:0] e;
        bit          push, pop;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        clr_cnt       = clr;
        @(posedge clk);
        push = v && m_rdy;
        pop  = (mq.size() != 0) && ordy;
        e    = model(d);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(e);
        if (clr) m_cnt = 0;
        else if (push && e[0] && m_cnt < CNT_MAX) m_cnt++;
        m_rdy = (mq.size() < 2);
        @(negedge clk);
        compare();
    endtask

    function automatic logic [31:0] rand_word();
        int v;
        case ($urandom_range(0, 3))
            0: v = int'($urandom_range(0, 65535)) - 32768;
            1: begin
                case ($urandom_range(0, 5))
                    0: v = 32767;
                    1: v = 32768;
                    2: v = -32768;
                    3: v = -32769;
                    4: v = 32'h7FFFFFFF;
                    default: v = 32'h80000000;
                endcase
            end
            default: v = int'($urandom());
        endcase
        return 32'(v);
    endfunction

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        clr_cnt       = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(bus.in_ready), 32'd0);
        step(0, 32'h0, 1, 0);
        chk("ready_after_edge", 32'(bus.in_ready), 32'd1);

        step(1, 32'hFFFF8001, 1, 0);
        chk("neg_in_range_data", 32'(bus.out_data), 32'h8001);
        chk("neg_in_range_ovf", 32'(bus.out_ovf), 32'd0);
        chk("neg_in_range_cnt", 32'(ovf_cnt), 32'd0);

        step(1, 32'h00012345, 1, 0);
        chk("pos_ovf_data", 32'(bus.out_data), SAT ? 32'h7FFF : 32'h2345);
        chk("pos_ovf_flag", 32'(bus.out_ovf), 32'd1);
        chk("pos_ovf_cnt", 32'(ovf_cnt), 32'd1);

        step(1, 32'h80000000, 1, 0);
        chk("neg_ovf_data", 32'(bus.out_data), SAT ? 32'h8000 : 32'h0000);
        chk("neg_ovf_flag", 32'(bus.out_ovf), 32'd1);

        step(0, 32'h0, 1, 0);
        step(1, 32'h11, 0, 0);
        step(1, 32'h22, 0, 0);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        step(1, 32'h33, 0, 0);
        chk("held_head", 32'(bus.out_data), 32'h0011);
        step(1, 32'h33, 1, 0);
        chk("pop1_data", 32'(bus.out_data), 32'h0022);
        chk("pop1_ready", 32'(bus.in_ready), 32'd1);
        step(1, 32'h33, 1, 0);
        chk("third_data", 32'(bus.out_data), 32'h0033);
        step(0, 32'h0, 1, 0);
        chk("drained", 32'(bus.out_valid), 32'd0);

        step(0, 32'h0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 32'h00010000, 1, 0);
            chk("sat_cnt", 32'(ovf_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        step(1, 32'h00010000, 1, 1);
        chk("clr_priority", 32'(ovf_cnt), 32'd0);

        step(1, 32'h44, 0, 0);
        step(1, 32'h55, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_in_ready", 32'(bus.in_ready), 32'd0);
        chk("async_out_data", 32'(bus.out_data), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rerst_ready_low", 32'(bus.in_ready), 32'd0);
        step(0, 32'h0, 1, 0);
        chk("rerst_ready_high", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            step(bit'($urandom_range(0, 3) != 0), rand_word(),
                 bit'($urandom_range(0, 2) != 0),
                 bit'($urandom_range(0, 31) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sign_narrow.md
SIGN_NARROW -- requirements
Module: sign_narrow

Interface
- REQ-001 Parameter: CNT_W, 16, width of overflow event counter.
- REQ-002 clk  input  1  single clock; all state updates on rising edge.
- REQ-003 rst_n  input  1  asynchronous, active-low reset.
- REQ-004 in_valid  input  1  upstream word present.
- REQ-005 in_ready  output  1  block can accept a word this cycle.
- REQ-006 in_data  input  32  signed word to narrow to 16 bits.
- REQ-007 out_valid  output  1  narrowed halfword present.
- REQ-008 out_ready  input  1  downstream accepts halfword this cycle.
- REQ-009 out_data  output  16  narrowed halfword.
- REQ-010 out_ovf  output  1  in_data was not representable as signed 16-bit.
- REQ-011 clr_cnt  input  1  synchronous clear of ovf_cnt.
- REQ-012 ovf_cnt  output  CNT_W  count of accepted overflowing words.

Function
- REQ-013 Transfer SHALL occur on an input when in_valid & in_ready, and on an output when out_valid & out_ready, at a rising clk edge.
- REQ-014 Overflow SHALL be flagged when in_data[31:15] are not all equal.
- REQ-015 Non-overflowing word: out_data SHALL equal in_data[15:0], out_ovf SHALL be 0.
- REQ-016 Storage SHALL be a 2-entry FIFO; entries hold {out_data, out_ovf}; order preserved.
- REQ-017 Latency: word accepted at edge N SHALL appear on out_* (out_valid=1) after edge N when FIFO was empty.
- REQ-018 in_ready SHALL be a registered signal equal to (occupancy < 2); no combinational path from out_ready to in_ready.
- REQ-019 When full and out_ready=1, in_ready SHALL still be 0 that cycle; input accepted next cycle.
- REQ-020 Simultaneous push and pop SHALL keep occupancy unchanged.
- REQ-021 out_data/out_ovf SHALL be held stable while out_valid=1 and out_ready=0.
- REQ-022 ovf_cnt SHALL increment by 1 on each accepted word with overflow; saturates at all-ones (no wrap).
- REQ-023 clr_cnt SHALL take priority: clear and overflow acceptance in same cycle yields ovf_cnt=0.

Reset
- REQ-024 rst_n low SHALL asynchronously force: occupancy 0, out_valid 0, out_data 0, out_ovf 0, ovf_cnt 0, in_ready 0.
- REQ-025 in_ready SHALL rise on the first edge after rst_n deasserts.
- REQ-026 Reset mid-transfer SHALL discard all buffered entries; no partial output afterward.

Configuration
- REQ-027 Macro SIGN_NARROW_SAT_EN SHALL select saturation.
- REQ-028 With SIGN_NARROW_SAT_EN defined: overflowing word yields out_data 0x7FFF if in_data[31]=0, 0x8000 if 1; out_ovf still 1.
- REQ-029 Without it: overflowing word yields out_data=in_data[15:0] (truncation), out_ovf=1.

Structure
- REQ-030 Package sign_narrow_pkg SHALL hold WORD_W=32, HALF_W=16, HALF_MAX=16'h7FFF, HALF_MIN=16'h8000 and the entry struct type {data, ovf}.
- REQ-031 The 2-entry FIFO SHALL be sub-module narrow_fifo2 (parameterised width, registered full flag); sign_narrow holds narrowing logic and counter.

Verification
- REQ-032 in_data=0xFFFF8001, out_ready=1 -> next cycle out_data=0x8001, out_ovf=0, ovf_cnt=0.
- REQ-033 in_data=0x00012345 -> out_ovf=1, ovf_cnt=1; out_data=0x7FFF with SAT_EN, 0x2345 without.
- REQ-034 in_data=0x80000000 with SAT_EN -> out_data=0x8000, out_ovf=1.
- REQ-035 out_ready=0, push 3 words back-to-back -> in_ready 0 after 2nd accept, 3rd held; release out_ready -> outputs in order, 3rd accepted cycle after first pop.
- REQ-036 CNT_W=2, four overflow words -> ovf_cnt 1,2,3,3; clr_cnt with 5th overflow word -> ovf_cnt=0.
- REQ-037 rst_n low with 2 entries buffered -> out_valid=0 immediately (asynchronous), in_ready=1 one edge after release.
